// File: rtl/inst_mem_pipelined.sv
// ---------------------------------------------------------------------------
// inst_mem_pipelined
//   Instruction memory for the MIPS fetch path. It sits between the PC/fetch
//   stage and decode. A fetch request uses a valid/ready handshake. The
//   response comes back through RD_LAT registered stages, also with a
//   valid/ready handshake. The stages advance in lockstep, so bubbles are kept.
//   A separate load port lets a loader program the array at run time.
//   A misaligned or out-of-range fetch returns rsp_err_o=1 with a NOP word.
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset (clears pipeline, not memory)
//   req_valid_i  fetch request valid
//   req_ready_o  fetch request accepted when req_valid_i && req_ready_o
//   req_addr_i   fetch byte address
//   rsp_valid_o  response valid
//   rsp_ready_i  downstream accepts response
//   rsp_inst_o   fetched instruction (0 on error)
//   rsp_err_o    response is for a misaligned / out-of-range address
//   flush_i      drop every in-flight fetch (branch redirect)
//   wr_en_i      load-port write strobe
//   wr_addr_i    load-port byte address
//   wr_data_i    load-port write data
// ---------------------------------------------------------------------------
module inst_mem_pipelined #(
  parameter int    DATA_W    = 32,
  parameter int    ADDR_W    = 32,
  parameter int    DEPTH     = 256,
  parameter int    RD_LAT    = 1,
  parameter string INIT_FILE = ""
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_inst_o,
  output logic              rsp_err_o,
  input  logic              flush_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] inst;
  } stage_t;

  // Misaligned, or any address bit above the word-index field is set
  // (i.e. addr >= DEPTH*4).
  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    return (a[1:0] != 2'b00) || (a[ADDR_W-1:IDX_W+2] != '0);
  endfunction

  // -------------------------------------------------------------------------
  // Storage. This block has no reset, so the contents survive rst_ni.
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [IDX_W-1:0] wr_idx, req_idx;
  logic             wr_bad, req_bad;

  assign wr_idx  = wr_addr_i[IDX_W+1:2];
  assign req_idx = req_addr_i[IDX_W+1:2];
  assign wr_bad  = addr_bad(wr_addr_i);
  assign req_bad = addr_bad(req_addr_i);

  // Writes are non-blocking. A fetch of the same word on the same edge
  // therefore captures the old contents (read-before-write).
  always_ff @(posedge clk_i) begin
    if (wr_en_i && !wr_bad) mem_q[wr_idx] <= wr_data_i;
  end

  // -------------------------------------------------------------------------
  // Read pipeline: lockstep shift of valid and payload.
  // -------------------------------------------------------------------------
  logic   [RD_LAT-1:0] vld_pipe_q, vld_pipe_d;
  stage_t [RD_LAT-1:0] pay_q, pay_d;
  stage_t              in_pay;
  logic                adv;

  // The whole pipe moves unless the output is holding an unaccepted word.
  assign adv         = !vld_pipe_q[RD_LAT-1] || rsp_ready_i;
  assign req_ready_o = adv;

  // An error fetch never touches the array. It carries a NOP instead.
  always_comb begin
    in_pay      = '0;
    in_pay.err  = req_bad;
    if (!req_bad) in_pay.inst = mem_q[req_idx];
  end

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    pay_d      = pay_q;
    if (flush_i) begin
      // flush beats advance. A request presented this cycle is dropped too.
      vld_pipe_d = '0;
    end else if (adv) begin
      vld_pipe_d[0] = req_valid_i;
      pay_d[0]      = in_pay;
      for (int s = 1; s < RD_LAT; s++) begin
        vld_pipe_d[s] = vld_pipe_q[s-1];
        pay_d[s]      = pay_q[s-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_pipe_q <= '0;
      pay_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      pay_q      <= pay_d;
    end
  end

  assign rsp_valid_o = vld_pipe_q[RD_LAT-1];
  assign rsp_inst_o  = pay_q[RD_LAT-1].inst;
  assign rsp_err_o   = pay_q[RD_LAT-1].err;

endmodule

// File: tb/tb_inst_mem_pipelined.sv
// ---------------------------------------------------------------------------
// tb_inst_mem_pipelined
//   Drives inst_mem_pipelined with RD_LAT=2. It runs directed scenarios first,
//   then randomized traffic. A reference model checks every cycle.
//   The model keeps a copy of the memory and a queue of outstanding fetches.
//   Each queue entry counts how many advancing edges it has seen. It becomes
//   visible on the response side after RD_LAT of them.
// ---------------------------------------------------------------------------
module tb_inst_mem_pipelined;

  localparam int RD_LAT = 2;
  localparam int DEPTH  = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_inst;
  logic        rsp_err;
  logic        flush = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;

  always #5 clk = ~clk;

  inst_mem_pipelined #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_inst_o(rsp_inst), .rsp_err_o(rsp_err),
    .flush_i(flush),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic        err;
    logic [31:0] inst;
    int          steps;
  } ent_t;

  logic [31:0] mem_m [DEPTH];
  ent_t        q[$];
  logic [32:0] got[$];   // {err, inst} of every handshaken response

  function automatic logic bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= DEPTH * 4);
  endfunction

  always @(negedge clk) begin
    logic ev;
    ent_t e;
    if (!rst_n) begin
      q.delete();
      chk("rst_vld", rsp_valid, 0);
      chk("rst_rdy", req_ready, 1);
      chk("rst_inst", rsp_inst, 0);
      chk("rst_err", rsp_err, 0);
    end else begin
      ev = (q.size() > 0) && (q[0].steps == RD_LAT);
      chk("rsp_valid", rsp_valid, ev);
      chk("req_ready", req_ready, !ev || rsp_ready);
      if (ev) begin
        chk("rsp_inst", rsp_inst, q[0].inst);
        chk("rsp_err", rsp_err, q[0].err);
        if (rsp_ready) got.push_back({rsp_err, rsp_inst});
      end
      if (flush) q.delete();
      else if (!ev || rsp_ready) begin
        if (ev) void'(q.pop_front());
        foreach (q[i]) q[i].steps++;
        if (req_valid) begin
          e.err   = bad(req_addr);
          e.inst  = e.err ? 32'h0 : mem_m[req_addr[9:2]];
          e.steps = 1;
          q.push_back(e);
        end
      end
      // Applied after the read above: read-before-write.
      if (wr_en && !bad(wr_addr)) mem_m[wr_addr[9:2]] = wr_data;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input logic v, input logic [31:0] a, input logic rr,
                     input logic fl, output logic acc);
    req_valid = v; req_addr = a; rsp_ready = rr; flush = fl;
    @(negedge clk);
    acc = v && req_ready;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, acc);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic acc;
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc(1'b0, 32'h0, 1'b1, 1'b0, acc);
    wr_en = 1'b0;
  endtask

  task automatic chk_got(input string tag, input int idx, input logic [32:0] exp);
    if (got.size() > idx) chk(tag, got[idx], exp);
    else chk({tag, "_missing"}, got.size(), idx + 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic acc;
    int   cnt;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Background image, then the program words at 0..12.
    for (int i = 0; i < DEPTH; i++) wr(i * 4, $urandom);
    wr(32'h0, 32'h2008_0005);
    wr(32'h4, 32'h2009_0003);
    wr(32'h8, 32'h0109_5020);
    wr(32'hC, 32'hAC0A_0000);

    // 1: back-to-back fetches, latency RD_LAT
    got.delete();
    cyc(1'b1, 32'h0, 1'b1, 1'b0, acc);
    chk("t1_lat_pre", rsp_valid, 0);
    cyc(1'b1, 32'h4, 1'b1, 1'b0, acc);
    chk("t1_lat_vld", rsp_valid, 1);
    chk("t1_lat_inst", rsp_inst, 32'h2008_0005);
    cyc(1'b1, 32'h8, 1'b1, 1'b0, acc);
    cyc(1'b1, 32'hC, 1'b1, 1'b0, acc);
    idle(4);
    chk("t1_count", got.size(), 4);
    chk_got("t1_w0", 0, {1'b0, 32'h2008_0005});
    chk_got("t1_w1", 1, {1'b0, 32'h2009_0003});
    chk_got("t1_w2", 2, {1'b0, 32'h0109_5020});
    chk_got("t1_w3", 3, {1'b0, 32'hAC0A_0000});

    // 2: stall for 3 cycles after first rsp_valid
    got.delete();
    cyc(1'b1, 32'h0, 1'b1, 1'b0, acc);
    cyc(1'b1, 32'h4, 1'b1, 1'b0, acc);
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_addr = 32'h8; rsp_ready = 1'b0;
      @(negedge clk);
      chk("t2_stall_vld", rsp_valid, 1);
      chk("t2_stall_inst", rsp_inst, 32'h2008_0005);
      chk("t2_stall_rdy", req_ready, 0);
      @(posedge clk); #1;
    end
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) cyc(1'b1, 32'h8, 1'b1, 1'b0, acc);
    chk("t2_accept8", acc, 1);
    idle(5);
    chk("t2_count", got.size(), 3);
    chk_got("t2_w0", 0, {1'b0, 32'h2008_0005});
    chk_got("t2_w1", 1, {1'b0, 32'h2009_0003});
    chk_got("t2_w2", 2, {1'b0, 32'h0109_5020});

    // 3: error fetches and ignored writes
    got.delete();
    cyc(1'b1, 32'h2, 1'b1, 1'b0, acc);
    cyc(1'b1, DEPTH * 4, 1'b1, 1'b0, acc);
    idle(3);
    wr(32'h401, 32'hFFFF_FFFF);
    wr(32'h1, 32'hFFFF_FFFF);
    cyc(1'b1, 32'h0, 1'b1, 1'b0, acc);
    idle(3);
    chk_got("t3_misalign", 0, {1'b1, 32'h0});
    chk_got("t3_range", 1, {1'b1, 32'h0});
    chk_got("t3_unchanged", 2, {1'b0, 32'h2008_0005});

    // 4: flush with a same-cycle request
    got.delete();
    cyc(1'b1, 32'h4, 1'b1, 1'b0, acc);
    cyc(1'b1, 32'h8, 1'b1, 1'b0, acc);
    cyc(1'b1, 32'hC, 1'b1, 1'b1, acc);
    chk("t4_flush_vld", rsp_valid, 0);
    idle(4);
    cnt = 0;
    foreach (got[i]) if (got[i] == {1'b0, 32'hAC0A_0000}) cnt++;
    chk("t4_dropped12", cnt, 0);
    got.delete();
    cyc(1'b1, 32'hC, 1'b1, 1'b0, acc);
    idle(3);
    chk_got("t4_refetch", 0, {1'b0, 32'hAC0A_0000});

    // 5: write/read collision
    got.delete();
    wr_en = 1'b1; wr_addr = 32'h4; wr_data = 32'hDEAD_BEEF;
    cyc(1'b1, 32'h4, 1'b1, 1'b0, acc);
    wr_en = 1'b0;
    cyc(1'b1, 32'h4, 1'b1, 1'b0, acc);
    idle(3);
    chk_got("t5_old", 0, {1'b0, 32'h2009_0003});
    chk_got("t5_new", 1, {1'b0, 32'hDEAD_BEEF});

    // 6: asynchronous reset mid-stall
    cyc(1'b1, 32'h0, 1'b0, 1'b0, acc);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, acc);
    chk("t6_pre_vld", rsp_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_vld", rsp_valid, 0);
    chk("t6_async_inst", rsp_inst, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    got.delete();
    cyc(1'b1, 32'h0, 1'b1, 1'b0, acc);
    idle(3);
    chk_got("t6_retained", 0, {1'b0, 32'h2008_0005});

    // Randomized traffic, checked cycle by cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? $urandom : {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      if ($urandom_range(0, 3) == 0) begin
        wr_en   = 1'b1;
        wr_addr = ($urandom_range(0, 1) == 0) ? a : $urandom_range(0, 1100);
        wr_data = $urandom;
      end
      cyc($urandom_range(0, 3) != 0, a, $urandom_range(0, 2) != 0,
          $urandom_range(0, 31) == 0, acc);
      wr_en = 1'b0;
    end

    // Drain: every accepted fetch must come out, bounded wait.
    for (int i = 0; i < 20 && (q.size() != 0 || rsp_valid); i++) idle(1);
    chk("drain_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
